arm7tdmi_decode: RTL and testbench
==================================

Name: arm7tdmi_decode

Overview:
- ARM-state decode stage directly downstream of the fetch stage; consumes instruction/pc/instr_valid and drives a registered decoded bundle to execute.
- Classifies the instruction, extracts register fields, expands immediates/offsets.
- Sequences LDM/STM into one micro-op per transferred register, holding fetch via decode_busy.
- Thumb decode is out of scope; in Thumb state every instruction decodes as UNDEF.

Parameters:
- XLEN, 32, datapath/address width (only 32 supported)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- instruction  in  32  instruction word from fetch
- pc_in  in  32  address of instruction
- instr_valid  in  1  instruction/pc_in valid
- thumb_mode  in  1  CPSR.T
- stall  in  1  execute cannot accept; hold outputs
- flush  in  1  discard contents (branch/exception)
- decode_busy  out  1  stall to fetch; multi-transfer in progress
- dec_valid  out  1  decoded bundle valid
- dec_pc  out  32  pc of decoded instruction
- dec_class  out  4  instr_class_t
- dec_cond  out  4  condition field [31:28]
- dec_rn, dec_rd, dec_rm, dec_rs  out  4 each  register fields
- dec_alu_op  out  4  DP opcode [24:21]
- dec_set_flags  out  1  S bit
- dec_imm  out  32  expanded immediate/offset
- dec_imm_valid  out  1  operand 2 / offset is immediate
- dec_load, dec_store  out  1 each  memory direction
- dec_pre, dec_up, dec_byte, dec_wb  out  1 each  P/U/B/W bits
- dec_xfer_reg  out  4  LDM/STM register this micro-op
- dec_xfer_first, dec_xfer_last  out  1 each  micro-op position
- dec_xfer_count  out  5  popcount of register list (0 list -> 1)

Behaviour:
- Reset: all outputs 0, dec_class = CLS_NOP, state IDLE.
- Accept = instr_valid && !stall && !decode_busy && !flush. On accept, outputs register decode of input: latency 1 cycle; dec_valid=1 next cycle.
- No accept and !stall: dec_valid<=0. stall=1: all outputs hold, sequencer does not advance.
- flush: highest priority; next cycle dec_valid=0, decode_busy=0, state IDLE, abandoning any multi-transfer. Also applies with stall=1.
- Classes, priority order: MUL (mask 0x0FC000F0==0x00000090), MULL (0x0F8000F0==0x00800090), SWP, BX (0x0FFFFFF0==0x012FFF10), LDRH/STRH/LDRSB/LDRSH, DP, LDR_STR, LDM_STM, B_BL, COPROC, SWI, UNDEF. Thumb: UNDEF.
- Immediates:
  - DP: imm8 rotated right by 2*rot4.
  - LDR/STR: imm12 zero-extended.
  - Halfword: {[11:8],[3:0]} zero-extended.
  - B/BL: sign-extend(imm24)<<2; no pc+8 added here. dec_wb = L bit for BL.
- Non-applicable fields: 0.
- LDM/STM sequencer, states IDLE, MULTI:
  - On accept: emit first micro-op with lowest set bit, dec_xfer_first=1, dec_xfer_count=popcount.
  - If >1 bits set: go MULTI, decode_busy=1 combinationally from the next cycle.
  - MULTI, each !stall cycle: emit next ascending bit, clear it.
  - Last bit: dec_xfer_last=1, return IDLE, decode_busy=0 in that same cycle, so a new instruction is accepted the cycle after.
  - Empty list: single micro-op, reg 15, first=last=1, count=1.
  - Non-LDM/STM: first=last=1, count=0.
  - dec_pc, cond, rn and P/U/W hold constant across all micro-ops.
  - dec_wb asserted only on the first micro-op.

Optional Feature:
- ARM7TDMI_DECODE_PERF_EN defined: adds outputs perf_decoded (32) and perf_busy_cycles (32), both reset 0.
  - perf_decoded increments per accept, cleared only by reset.
  - perf_busy_cycles increments each cycle decode_busy=1, cleared only by reset.
- Undefined: ports absent, no counters.

Decomposition:
- arm7tdmi_pkg gains instr_class_t, 4-bit enum: CLS_NOP=0, DP, MUL, MULL, SWP, BX, LDR_STR, LDRH, LDM_STM, B_BL, SWI, COPROC, UNDEF.
- Class mask/match constants also go in arm7tdmi_pkg.
- Sub-module arm7tdmi_reglist_seq: priority-encoder plus clear-bit register-list walker with popcount.

Test Plan:
- E3A01C02 (MOV r1,#0x200) valid one cycle -> next cycle dec_valid=1, class DP, rd=1, imm=0x00000200, imm_valid=1.
- EAFFFFFE at pc 0x100 -> class B_BL, imm=0xFFFFFFF8, dec_pc=0x100.
- E8BD000E (LDMIA sp!,{r1-r3}) -> 3 consecutive micro-ops reg 1,2,3.
  - count=3; first on r1, last on r3; wb only on first.
  - decode_busy high 2 cycles; stall mid-sequence holds reg 2 for stall duration.
- LDM with 8 registers, flush after 2nd micro-op -> next cycle dec_valid=0, decode_busy=0, a following instr_valid accepted.
- E8900000 (empty list) -> one micro-op reg 15, first=last=1, count=1, decode_busy never asserted.
- thumb_mode=1 with any word -> class UNDEF; rst_n low mid-LDM -> all outputs 0 asynchronously, state IDLE.

Source files
------------

// File: rtl/arm7tdmi_pkg.sv
// rtl/arm7tdmi_pkg.sv - ARM-state decode types, class match constants and helpers
package arm7tdmi_pkg;

    typedef enum logic [3:0] {
        CLS_NOP     = 4'd0,
        CLS_DP      = 4'd1,
        CLS_MUL     = 4'd2,
        CLS_MULL    = 4'd3,
        CLS_SWP     = 4'd4,
        CLS_BX      = 4'd5,
        CLS_LDR_STR = 4'd6,
        CLS_LDRH    = 4'd7,
        CLS_LDM_STM = 4'd8,
        CLS_B_BL    = 4'd9,
        CLS_SWI     = 4'd10,
        CLS_COPROC  = 4'd11,
        CLS_UNDEF   = 4'd12
    } instr_class_t;

    typedef enum logic {
        S_IDLE,
        S_MULTI
    } seq_state_t;

    localparam logic [31:0] MUL_MASK   = 32'h0FC0_00F0;
    localparam logic [31:0] MUL_MATCH  = 32'h0000_0090;
    localparam logic [31:0] MULL_MASK  = 32'h0F80_00F0;
    localparam logic [31:0] MULL_MATCH = 32'h0080_0090;
    localparam logic [31:0] SWP_MASK   = 32'h0FB0_0FF0;
    localparam logic [31:0] SWP_MATCH  = 32'h0100_0090;
    localparam logic [31:0] BX_MASK    = 32'h0FFF_FFF0;
    localparam logic [31:0] BX_MATCH   = 32'h012F_FF10;
    localparam logic [31:0] HW_MASK    = 32'h0E00_0090;
    localparam logic [31:0] HW_MATCH   = 32'h0000_0090;

    localparam logic [3:0] COND_AL = 4'hE;

    typedef struct packed {
        instr_class_t cls;
        logic [3:0]   cond;
        logic [3:0]   rn;
        logic [3:0]   rd;
        logic [3:0]   rm;
        logic [3:0]   rs;
        logic [3:0]   alu_op;
        logic         set_flags;
        logic [31:0]  imm;
        logic         imm_valid;
        logic         load;
        logic         store;
        logic         pre;
        logic         up;
        logic         byte_sel;
        logic         wb;
        logic [3:0]   xfer_reg;
        logic         xfer_first;
        logic         xfer_last;
        logic [4:0]   xfer_count;
    } dec_bundle_t;

    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] sh);
        logic [63:0] dbl;
        dbl = {x, x} >> sh;
        return dbl[31:0];
    endfunction

    // Earlier tests win: the multiply/swap/halfword encodings overlap the DP space.
    function automatic instr_class_t classify(input logic [31:0] i);
        instr_class_t c;
        if ((i & MUL_MASK) == MUL_MATCH)                          c = CLS_MUL;
        else if ((i & MULL_MASK) == MULL_MATCH)                   c = CLS_MULL;
        else if ((i & SWP_MASK) == SWP_MATCH)                     c = CLS_SWP;
        else if ((i & BX_MASK) == BX_MATCH)                       c = CLS_BX;
        else if ((i & HW_MASK) == HW_MATCH && i[6:5] != 2'b00)    c = CLS_LDRH;
        else if (i[27:26] == 2'b00)                               c = CLS_DP;
        else if (i[27:26] == 2'b01 && !(i[25] && i[4]))           c = CLS_LDR_STR;
        else if (i[27:25] == 3'b100)                              c = CLS_LDM_STM;
        else if (i[27:25] == 3'b101)                              c = CLS_B_BL;
        else if (i[27:25] == 3'b110 || i[27:24] == 4'b1110)       c = CLS_COPROC;
        else if (i[27:24] == 4'b1111)                             c = CLS_SWI;
        else                                                      c = CLS_UNDEF;
        return c;
    endfunction

endpackage

// File: rtl/arm7tdmi_reglist_seq.sv
// rtl/arm7tdmi_reglist_seq.sv - LDM/STM register-list walker: priority encoder, clear-lowest-bit, popcount
module arm7tdmi_reglist_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] list_in,
    input  logic        load,
    input  logic        advance,
    input  logic        clear,
    output logic [3:0]  first_reg,
    output logic [4:0]  list_count,
    output logic        multi,
    output logic [3:0]  next_reg,
    output logic        next_last
);

    logic [15:0] remaining;
    logic [4:0]  pop;

    always_comb begin
        first_reg = 4'd15;
        next_reg  = 4'd0;
        pop       = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            if (list_in[i])   first_reg = 4'(i);
            if (remaining[i]) next_reg  = 4'(i);
        end
        for (int i = 0; i < 16; i++) begin
            pop = pop + {4'b0, list_in[i]};
        end
    end

    // An empty list still transfers r15 once, so it counts as one.
    assign list_count = (pop == 5'd0) ? 5'd1 : pop;
    assign multi      = (pop > 5'd1);
    assign next_last  = ((remaining & (remaining - 16'd1)) == 16'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
        end else if (clear) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= list_in & (list_in - 16'd1);
        end else if (advance) begin
            remaining <= remaining & (remaining - 16'd1);
        end
    end

endmodule

// File: rtl/arm7tdmi_decode.sv
// rtl/arm7tdmi_decode.sv - ARM-state decode stage with LDM/STM micro-op sequencing; ARM7TDMI_DECODE_PERF_EN adds perf counters
module arm7tdmi_decode
    import arm7tdmi_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc_in,
    input  logic            instr_valid,
    input  logic            thumb_mode,
    input  logic            stall,
    input  logic            flush,
    output logic            decode_busy,
    output logic            dec_valid,
    output logic [XLEN-1:0] dec_pc,
    output logic [3:0]      dec_class,
    output logic [3:0]      dec_cond,
    output logic [3:0]      dec_rn,
    output logic [3:0]      dec_rd,
    output logic [3:0]      dec_rm,
    output logic [3:0]      dec_rs,
    output logic [3:0]      dec_alu_op,
    output logic            dec_set_flags,
    output logic [31:0]     dec_imm,
    output logic            dec_imm_valid,
    output logic            dec_load,
    output logic            dec_store,
    output logic            dec_pre,
    output logic            dec_up,
    output logic            dec_byte,
    output logic            dec_wb,
    output logic [3:0]      dec_xfer_reg,
    output logic            dec_xfer_first,
    output logic            dec_xfer_last,
    output logic [4:0]      dec_xfer_count
`ifdef ARM7TDMI_DECODE_PERF_EN
    ,
    output logic [31:0]     perf_decoded,
    output logic [31:0]     perf_busy_cycles
`endif
);

    seq_state_t      state, state_next;
    instr_class_t    cls;
    dec_bundle_t     d, q;
    logic [XLEN-1:0] q_pc;
    logic            accept, seq_load, seq_advance;
    logic [3:0]      first_reg, next_reg;
    logic [4:0]      list_count;
    logic            multi, next_last;

    assign decode_busy = (state == S_MULTI);
    assign accept      = instr_valid && !stall && !decode_busy && !flush;
    assign seq_load    = accept && (cls == CLS_LDM_STM);
    assign seq_advance = decode_busy && !stall && !flush;

    arm7tdmi_reglist_seq u_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .list_in    (instruction[15:0]),
        .load       (seq_load),
        .advance    (seq_advance),
        .clear      (flush),
        .first_reg  (first_reg),
        .list_count (list_count),
        .multi      (multi),
        .next_reg   (next_reg),
        .next_last  (next_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush)                          state_next = S_IDLE;
        else if (seq_load && multi)         state_next = S_MULTI;
        else if (seq_advance && next_last)  state_next = S_IDLE;
    end

    // Thumb words get condition AL so execute always takes the UNDEF trap.
    always_comb begin
        cls          = thumb_mode ? CLS_UNDEF : classify(instruction);
        d            = '0;
        d.cls        = cls;
        d.cond       = thumb_mode ? COND_AL : instruction[31:28];
        d.xfer_first = 1'b1;
        d.xfer_last  = 1'b1;
        case (cls)
            CLS_DP: begin
                d.rn        = instruction[19:16];
                d.rd        = instruction[15:12];
                d.alu_op    = instruction[24:21];
                d.set_flags = instruction[20];
                if (instruction[25]) begin
                    d.imm       = ror32({24'h0, instruction[7:0]}, {instruction[11:8], 1'b0});
                    d.imm_valid = 1'b1;
                end else begin
                    d.rm = instruction[3:0];
                    if (instruction[4]) d.rs = instruction[11:8];
                end
            end
            CLS_MUL, CLS_MULL: begin
                d.rd        = instruction[19:16];
                d.rn        = instruction[15:12];
                d.rs        = instruction[11:8];
                d.rm        = instruction[3:0];
                d.set_flags = instruction[20];
            end
            CLS_SWP: begin
                d.rn       = instruction[19:16];
                d.rd       = instruction[15:12];
                d.rm       = instruction[3:0];
                d.byte_sel = instruction[22];
                d.load     = 1'b1;
                d.store    = 1'b1;
            end
            CLS_BX: d.rm = instruction[3:0];
            CLS_LDRH: begin
                d.rn        = instruction[19:16];
                d.rd        = instruction[15:12];
                d.pre       = instruction[24];
                d.up        = instruction[23];
                d.wb        = instruction[21];
                d.load      = instruction[20];
                d.store     = !instruction[20];
                d.imm_valid = instruction[22];
                if (instruction[22]) d.imm = {24'h0, instruction[11:8], instruction[3:0]};
                else                 d.rm  = instruction[3:0];
            end
            CLS_LDR_STR: begin
                d.rn        = instruction[19:16];
                d.rd        = instruction[15:12];
                d.pre       = instruction[24];
                d.up        = instruction[23];
                d.byte_sel  = instruction[22];
                d.wb        = instruction[21];
                d.load      = instruction[20];
                d.store     = !instruction[20];
                d.imm_valid = !instruction[25];
                if (instruction[25]) d.rm  = instruction[3:0];
                else                 d.imm = {20'h0, instruction[11:0]};
            end
            CLS_LDM_STM: begin
                d.rn         = instruction[19:16];
                d.pre        = instruction[24];
                d.up         = instruction[23];
                d.wb         = instruction[21];
                d.load       = instruction[20];
                d.store      = !instruction[20];
                d.xfer_reg   = first_reg;
                d.xfer_count = list_count;
                d.xfer_last  = !multi;
            end
            CLS_B_BL: begin
                d.imm       = {{6{instruction[23]}}, instruction[23:0], 2'b00};
                d.imm_valid = 1'b1;
                d.wb        = instruction[24];
            end
            default: ;
        endcase
    end

    // Follow-on micro-ops only rewrite the per-transfer fields; everything else holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q         <= '0;
            q_pc      <= '0;
            dec_valid <= 1'b0;
        end else if (flush) begin
            dec_valid <= 1'b0;
        end else if (!stall) begin
            if (accept) begin
                q         <= d;
                q_pc      <= pc_in;
                dec_valid <= 1'b1;
            end else if (decode_busy) begin
                q.xfer_reg   <= next_reg;
                q.xfer_first <= 1'b0;
                q.xfer_last  <= next_last;
                q.wb         <= 1'b0;
                dec_valid    <= 1'b1;
            end else begin
                dec_valid <= 1'b0;
            end
        end
    end

    assign dec_pc         = q_pc;
    assign dec_class      = q.cls;
    assign dec_cond       = q.cond;
    assign dec_rn         = q.rn;
    assign dec_rd         = q.rd;
    assign dec_rm         = q.rm;
    assign dec_rs         = q.rs;
    assign dec_alu_op     = q.alu_op;
    assign dec_set_flags  = q.set_flags;
    assign dec_imm        = q.imm;
    assign dec_imm_valid  = q.imm_valid;
    assign dec_load       = q.load;
    assign dec_store      = q.store;
    assign dec_pre        = q.pre;
    assign dec_up         = q.up;
    assign dec_byte       = q.byte_sel;
    assign dec_wb         = q.wb;
    assign dec_xfer_reg   = q.xfer_reg;
    assign dec_xfer_first = q.xfer_first;
    assign dec_xfer_last  = q.xfer_last;
    assign dec_xfer_count = q.xfer_count;

`ifdef ARM7TDMI_DECODE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_decoded     <= '0;
            perf_busy_cycles <= '0;
        end else begin
            if (accept)      perf_decoded     <= perf_decoded + 32'd1;
            if (decode_busy) perf_busy_cycles <= perf_busy_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_arm7tdmi_decode.sv
// tb/tb_arm7tdmi_decode.sv - randomized bench for arm7tdmi_decode against a micro-op queue model
module tb_arm7tdmi_decode;

    localparam logic [3:0] K_NOP = 0, K_DP = 1, K_MUL = 2, K_MULL = 3, K_SWP = 4, K_BX = 5;
    localparam logic [3:0] K_LDR = 6, K_LDRH = 7, K_LDM = 8, K_B = 9, K_SWI = 10, K_COP = 11, K_UND = 12;

    logic        clk, rst_n, instr_valid, thumb_mode, stall, flush;
    logic [31:0] instruction, pc_in;
    logic        decode_busy, dec_valid, dec_set_flags, dec_imm_valid, dec_load, dec_store;
    logic        dec_pre, dec_up, dec_byte, dec_wb, dec_xfer_first, dec_xfer_last;
    logic [31:0] dec_pc, dec_imm;
    logic [3:0]  dec_class, dec_cond, dec_rn, dec_rd, dec_rm, dec_rs, dec_alu_op, dec_xfer_reg;
    logic [4:0]  dec_xfer_count;

    arm7tdmi_decode #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .pc_in(pc_in),
        .instr_valid(instr_valid), .thumb_mode(thumb_mode), .stall(stall), .flush(flush),
        .decode_busy(decode_busy), .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_class(dec_class),
        .dec_cond(dec_cond), .dec_rn(dec_rn), .dec_rd(dec_rd), .dec_rm(dec_rm), .dec_rs(dec_rs),
        .dec_alu_op(dec_alu_op), .dec_set_flags(dec_set_flags), .dec_imm(dec_imm),
        .dec_imm_valid(dec_imm_valid), .dec_load(dec_load), .dec_store(dec_store),
        .dec_pre(dec_pre), .dec_up(dec_up), .dec_byte(dec_byte), .dec_wb(dec_wb),
        .dec_xfer_reg(dec_xfer_reg), .dec_xfer_first(dec_xfer_first),
        .dec_xfer_last(dec_xfer_last), .dec_xfer_count(dec_xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, imm;
        logic [3:0]  cls, cond, rn, rd, rm, rs, alu, xreg;
        logic [4:0]  cnt;
        logic        sflag, immv, ld, st, pre, up, byt, wb, first, last;
    } exp_t;

    exp_t e;
    exp_t pending[$];
    logic exp_valid;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [3:0] ref_class(input logic [31:0] w, input logic th);
        if (th)                                          return K_UND;
        if ((w & 32'h0FC000F0) == 32'h00000090)          return K_MUL;
        if ((w & 32'h0F8000F0) == 32'h00800090)          return K_MULL;
        if (w[27:23] == 5'b00010 && w[21:20] == 2'b00 && w[11:4] == 8'h09) return K_SWP;
        if ((w & 32'h0FFFFFF0) == 32'h012FFF10)          return K_BX;
        if (w[27:25] == 3'b000 && w[7] && w[4] && w[6:5] != 2'b00) return K_LDRH;
        case (w[27:25])
            3'b000, 3'b001: return K_DP;
            3'b010:         return K_LDR;
            3'b011:         return w[4] ? K_UND : K_LDR;
            3'b100:         return K_LDM;
            3'b101:         return K_B;
            3'b110:         return K_COP;
            default:        return w[24] ? K_SWI : K_COP;
        endcase
    endfunction

    task automatic model_decode(input logic [31:0] w, input logic th, input logic [31:0] pc);
        exp_t b;
        logic [31:0] x;
        int cnt, k;
        b = '{default: 0};
        b.pc = pc;
        b.cls = ref_class(w, th);
        b.cond = th ? 4'hE : w[31:28];
        b.first = 1; b.last = 1;
        case (b.cls)
            K_DP: begin
                b.rn = w[19:16]; b.rd = w[15:12]; b.alu = w[24:21]; b.sflag = w[20];
                if (w[25]) begin
                    x = {24'h0, w[7:0]};
                    for (int r = 0; r < 2 * w[11:8]; r++) x = {x[0], x[31:1]};
                    b.imm = x; b.immv = 1;
                end else begin
                    b.rm = w[3:0];
                    b.rs = w[4] ? w[11:8] : 4'h0;
                end
            end
            K_MUL, K_MULL: begin
                b.rd = w[19:16]; b.rn = w[15:12]; b.rs = w[11:8]; b.rm = w[3:0]; b.sflag = w[20];
            end
            K_SWP: begin
                b.rn = w[19:16]; b.rd = w[15:12]; b.rm = w[3:0]; b.byt = w[22]; b.ld = 1; b.st = 1;
            end
            K_BX: b.rm = w[3:0];
            K_LDRH: begin
                b.rn = w[19:16]; b.rd = w[15:12]; b.pre = w[24]; b.up = w[23]; b.wb = w[21];
                b.ld = w[20]; b.st = !w[20]; b.immv = w[22];
                b.imm = w[22] ? {24'h0, w[11:8], w[3:0]} : 32'h0;
                b.rm = w[22] ? 4'h0 : w[3:0];
            end
            K_LDR: begin
                b.rn = w[19:16]; b.rd = w[15:12]; b.pre = w[24]; b.up = w[23]; b.byt = w[22];
                b.wb = w[21]; b.ld = w[20]; b.st = !w[20]; b.immv = !w[25];
                b.imm = w[25] ? 32'h0 : {20'h0, w[11:0]};
                b.rm = w[25] ? w[3:0] : 4'h0;
            end
            K_B: begin
                b.imm = {{8{w[23]}}, w[23:0]} << 2; b.immv = 1; b.wb = w[24];
            end
            default: ;
        endcase
        if (b.cls == K_LDM) begin
            b.rn = w[19:16]; b.pre = w[24]; b.up = w[23]; b.ld = w[20]; b.st = !w[20];
            cnt = $countones(w[15:0]);
            if (cnt == 0) begin
                b.xreg = 15; b.cnt = 1; b.wb = w[21];
                pending.push_back(b);
            end else begin
                b.cnt = 5'(cnt);
                k = 0;
                for (int i = 0; i < 16; i++) begin
                    if (w[i]) begin
                        b.xreg = 4'(i);
                        b.first = (k == 0);
                        b.last = (k == cnt - 1);
                        b.wb = (k == 0) ? w[21] : 1'b0;
                        pending.push_back(b);
                        k++;
                    end
                end
            end
        end else begin
            pending.push_back(b);
        end
    endtask

    task automatic model_reset();
        e = '{default: 0};
        exp_valid = 0;
        pending.delete();
    endtask

    task automatic model_step();
        if (flush) begin
            exp_valid = 0;
            pending.delete();
        end else if (!stall) begin
            if (pending.size() > 0) begin
                e = pending.pop_front();
                exp_valid = 1;
            end else if (instr_valid) begin
                model_decode(instruction, thumb_mode, pc_in);
                e = pending.pop_front();
                exp_valid = 1;
            end else begin
                exp_valid = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("valid", dec_valid, exp_valid);
        check("busy", decode_busy, pending.size() > 0);
        check("pc", dec_pc, e.pc);
        check("class", dec_class, e.cls);
        check("cond", dec_cond, e.cond);
        check("rn", dec_rn, e.rn);
        check("rd", dec_rd, e.rd);
        check("rm", dec_rm, e.rm);
        check("rs", dec_rs, e.rs);
        check("alu_op", dec_alu_op, e.alu);
        check("set_flags", dec_set_flags, e.sflag);
        check("imm", dec_imm, e.imm);
        check("imm_valid", dec_imm_valid, e.immv);
        check("load", dec_load, e.ld);
        check("store", dec_store, e.st);
        check("pre", dec_pre, e.pre);
        check("up", dec_up, e.up);
        check("byte", dec_byte, e.byt);
        check("wb", dec_wb, e.wb);
        check("xfer_reg", dec_xfer_reg, e.xreg);
        check("xfer_first", dec_xfer_first, e.first);
        check("xfer_last", dec_xfer_last, e.last);
        check("xfer_count", dec_xfer_count, e.cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 7))
            0: w[27:26] = 2'b00;
            1: begin
                w[27:25] = 3'b100;
                w[15:0] = w[15:0] & 16'($urandom);
                if ($urandom_range(0, 3) == 0) w[15:0] = 16'h0;
            end
            2: w[27:26] = 2'b01;
            3: begin w[27:25] = 3'b000; w[7] = 1'b1; w[4] = 1'b1; end
            4: w[27:25] = 3'b101;
            5: begin w[27:22] = 6'b000000; w[7:4] = 4'b1001; end
            6: begin w[27:20] = 8'h12; w[19:4] = 16'hFFF1; end
            default: begin w[27:23] = 5'b00010; w[21:20] = 2'b00; w[11:4] = 8'h09; end
        endcase
        return w;
    endfunction

    initial begin
        rst_n = 0; instruction = 0; pc_in = 0; instr_valid = 0;
        thumb_mode = 0; stall = 0; flush = 0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        check("rst_class_nop", dec_class, 32'(K_NOP));
        rst_n = 1;
        tick();

        instruction = 32'hE3A01C02; pc_in = 32'h0; instr_valid = 1;
        tick();
        check("mov_valid", dec_valid, 1);
        check("mov_class", dec_class, 32'(K_DP));
        check("mov_rd", dec_rd, 1);
        check("mov_imm", dec_imm, 32'h200);
        check("mov_imm_valid", dec_imm_valid, 1);

        instruction = 32'hEAFFFFFE; pc_in = 32'h100;
        tick();
        check("b_class", dec_class, 32'(K_B));
        check("b_imm", dec_imm, 32'hFFFFFFF8);
        check("b_pc", dec_pc, 32'h100);

        instruction = 32'hE8BD000E; pc_in = 32'h200;
        tick();
        check("ldm_r1", dec_xfer_reg, 1);
        check("ldm_first", dec_xfer_first, 1);
        check("ldm_count", dec_xfer_count, 3);
        check("ldm_wb_first", dec_wb, 1);
        check("ldm_busy1", decode_busy, 1);
        instruction = 32'hE3A01C02; pc_in = 32'h204;
        tick();
        check("ldm_r2", dec_xfer_reg, 2);
        check("ldm_wb_second", dec_wb, 0);
        check("ldm_busy2", decode_busy, 1);
        stall = 1;
        repeat (3) begin
            tick();
            check("ldm_stall_r2", dec_xfer_reg, 2);
        end
        stall = 0;
        tick();
        check("ldm_r3", dec_xfer_reg, 3);
        check("ldm_last", dec_xfer_last, 1);
        check("ldm_busy_done", decode_busy, 0);
        check("ldm_pc_hold", dec_pc, 32'h200);
        tick();
        check("after_ldm_class", dec_class, 32'(K_DP));
        check("after_ldm_pc", dec_pc, 32'h204);
        instr_valid = 0;
        tick();

        instruction = 32'hE89000FF; pc_in = 32'h300; instr_valid = 1;
        tick();
        instruction = 32'hE3A01C02; pc_in = 32'h400;
        tick();
        check("ldm8_r1", dec_xfer_reg, 1);
        flush = 1;
        tick();
        check("flush_valid", dec_valid, 0);
        check("flush_busy", decode_busy, 0);
        flush = 0;
        tick();
        check("post_flush_valid", dec_valid, 1);
        check("post_flush_pc", dec_pc, 32'h400);
        instr_valid = 0;
        tick();

        instruction = 32'hE8900000; pc_in = 32'h500; instr_valid = 1;
        tick();
        check("empty_reg", dec_xfer_reg, 15);
        check("empty_first", dec_xfer_first, 1);
        check("empty_last", dec_xfer_last, 1);
        check("empty_count", dec_xfer_count, 1);
        check("empty_busy", decode_busy, 0);
        instr_valid = 0;
        tick();
        check("empty_busy_after", decode_busy, 0);

        thumb_mode = 1; instruction = $urandom; instr_valid = 1;
        tick();
        check("thumb_class", dec_class, 32'(K_UND));
        thumb_mode = 0; instr_valid = 0;
        tick();

        instruction = 32'hE89000FF; pc_in = 32'h600; instr_valid = 1;
        tick();
        instr_valid = 0;
        tick();
        #2 rst_n = 0;
        #1;
        check("arst_valid", dec_valid, 0);
        check("arst_busy", decode_busy, 0);
        check("arst_class", dec_class, 32'(K_NOP));
        check("arst_xfer_reg", dec_xfer_reg, 0);
        check("arst_pc", dec_pc, 0);
        check("arst_imm", dec_imm, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        compare_all();
        tick();

        for (int n = 0; n < 1500; n++) begin
            instr_valid = ($urandom_range(0, 99) < 70);
            stall       = ($urandom_range(0, 99) < 15);
            flush       = ($urandom_range(0, 99) < 4);
            thumb_mode  = ($urandom_range(0, 99) < 5);
            instruction = gen_instr();
            pc_in       = $urandom & 32'hFFFFFFFC;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
